mux4_rr_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 38 +++
 rtl/mux4to1.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, source
// count, index width and the rotating priority search.
package mux_arb_pkg;

   localparam int NUM_SRC = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Search from last+1 upward with wrap; the previous owner is looked at last.
   // Walking the offsets from farthest to nearest lets the nearest hit win
   // without an early exit.
   function automatic pick_t rr_pick(input logic [NUM_SRC-1:0] req,
                                     input logic [IDX_W-1:0]   last);
      pick_t            p;
      logic [IDX_W-1:0] idx;
      p.found = 1'b0;
      p.idx   = last;
      for (int k = NUM_SRC; k >= 1; k--) begin
         idx = last + IDX_W'(k);
         if (req[idx]) begin
            p.found = 1'b1;
            p.idx   = idx;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux4to1.sv
// Gate-level 4:1 bit multiplexer; {s0,s1} is the select index with s0 as MSB.
module mux4to1 (
   input  wire i0,
   input  wire i1,
   input  wire i2,
   input  wire i3,
   input  wire s0,
   input  wire s1,
   output wire y
);

   wire s0_n, s1_n;
   wire t0, t1, t2, t3;

   not u_n0 (s0_n, s0);
   not u_n1 (s1_n, s1);

   and u_a0 (t0, i0, s0_n, s1_n);
   and u_a1 (t1, i1, s0_n, s1);
   and u_a2 (t2, i2, s0,   s1_n);
   and u_a3 (t3, i3, s0,   s1);

   or  u_o  (y, t0, t1, t2, t3);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4to1 among four requesters.
// Optional hold timeout with forced eviction: define MUX_ARB_HOLD_TIMEOUT_EN.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       i0,
   input  logic       i1,
   input  logic       i2,
   input  logic       i3,
   output logic [3:0] gnt,
   output logic       s0,
   output logic       s1,
   output logic       busy,
   output logic       evict,
   output logic       y
);

   if (MAX_HOLD < 2) begin : g_bad_max_hold
      $error("mux4_rr_arbiter: MAX_HOLD must be at least 2");
   end

   state_t           state, state_n;
   logic [3:0]       gnt_n;
   logic [IDX_W-1:0] sel, sel_n;
   logic [IDX_W-1:0] last, last_n;
   pick_t            pick;
   logic             mux_y;

`ifdef MUX_ARB_HOLD_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD);
   logic [HOLD_W-1:0] hold, hold_n;
   logic              evict_q, evict_n;
`endif

   assign pick = rr_pick(req, last);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      last_n  = last;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
      hold_n  = hold;
      evict_n = 1'b0;
`endif
      case (state)
         ST_IDLE, ST_GAP: begin
            gnt_n = '0;
            if (pick.found) begin
               state_n         = ST_BUSY;
               gnt_n[pick.idx] = 1'b1;
               sel_n           = pick.idx;
               last_n          = pick.idx;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
               hold_n          = '0;
`endif
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!(|(req & gnt))) begin
               state_n = ST_GAP;
               gnt_n   = '0;
            end
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
            else if (hold == HOLD_W'(MAX_HOLD - 1)) begin
               // last already names the evicted source, so it is searched last.
               state_n = ST_GAP;
               gnt_n   = '0;
               evict_n = 1'b1;
            end else begin
               hold_n = hold + HOLD_W'(1);
            end
`endif
         end
         default: begin
            state_n = ST_IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state <= ST_IDLE;
         gnt   <= '0;
         sel   <= '0;
         last  <= IDX_W'(NUM_SRC - 1);
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         last  <= last_n;
      end
   end

`ifdef MUX_ARB_HOLD_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold    <= '0;
         evict_q <= 1'b0;
      end else begin
         hold    <= hold_n;
         evict_q <= evict_n;
      end
   end

   assign evict = evict_q;
`else
   assign evict = 1'b0;
`endif

   assign busy = (state == ST_BUSY);
   assign s0   = sel[1];
   assign s1   = sel[0];

   mux4to1 u_mux (
      .i0 (i0),
      .i1 (i1),
      .i2 (i2),
      .i3 (i3),
      .s0 (s0),
      .s1 (s1),
      .y  (mux_y)
   );

   // Gating with busy keeps y at 0 through GAP and IDLE while selects hold.
   assign y = mux_y & busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a behavioural owner/last model feeds
// expected outputs into a queue that a negedge monitor drains and compares.
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       i0, i1, i2, i3;
   logic [3:0] gnt;
   logic       s0, s1, busy, evict, y;

   typedef struct packed {
      logic [3:0] gnt;
      logic       busy;
      logic       s0;
      logic       s1;
      logic       evict;
      logic       y;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: who owns the line, who owned it last, for how long.
   int         m_owner;
   int         m_last;
   int         m_held;
   int         m_sel;
   logic       m_evict;
   logic       cur_rst;
   logic [3:0] cur_req;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .i0    (i0),
      .i1    (i1),
      .i2    (i2),
      .i3    (i3),
      .gnt   (gnt),
      .s0    (s0),
      .s1    (s1),
      .busy  (busy),
      .evict (evict),
      .y     (y)
   );

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
      end
   endtask

   task automatic model_step();
      if (cur_rst) begin
         m_owner = -1;
         m_last  = 3;
         m_held  = 0;
         m_sel   = 0;
         m_evict = 1'b0;
      end else begin
         m_evict = 1'b0;
         if (m_owner >= 0) begin
            if (!cur_req[m_owner]) begin
               m_owner = -1;
            end else if (TIMEOUT_EN && m_held == MAX_HOLD) begin
               m_owner = -1;
               m_evict = 1'b1;
            end else begin
               m_held++;
            end
         end else begin
            for (int k = 1; k <= 4; k++) begin
               int c;
               c = (m_last + k) % 4;
               if (m_owner < 0 && cur_req[c]) begin
                  m_owner = c;
                  m_last  = c;
                  m_sel   = c;
                  m_held  = 1;
               end
            end
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #2;
      model_step();
   endtask

   task automatic apply(input logic r, input logic [3:0] q);
      logic [3:0] ins;
      exp_t       e;
      cur_rst = r;
      cur_req = q;
      rst     = r;
      req     = q;
      ins     = 4'($urandom);
      {i3, i2, i1, i0} = ins;
      e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      e.busy  = (m_owner >= 0);
      e.s0    = m_sel[1];
      e.s1    = m_sel[0];
      e.evict = m_evict;
      e.y     = e.busy & ins[m_sel];
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic r, input logic [3:0] q);
      advance();
      apply(r, q);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("gnt", {5'b0, gnt}, {5'b0, e.gnt});
         check("busy_s0_s1_evict", {5'b0, busy, s0, s1, evict},
               {5'b0, e.busy, e.s0, e.s1, e.evict});
         check("y", {8'b0, y}, {8'b0, e.y});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] nreq;
      rst = 1'b1;
      req = 4'b0000;
      {i3, i2, i1, i0} = 4'b0000;
      cur_rst = 1'b1;
      cur_req = 4'b0000;
      m_owner = -1;
      m_last  = 3;
      m_held  = 0;
      m_sel   = 0;
      m_evict = 1'b0;

      // Reset held with everyone requesting, then source 0 wins first.
      cycle(1'b1, 4'b1111);
      cycle(1'b1, 4'b1111);
      repeat (3) cycle(1'b0, 4'b1111);

      // Rotation: all request, each owner drops after three busy cycles.
      repeat (24) begin
         advance();
         nreq = 4'b1111;
         if (m_owner >= 0 && m_held >= 3) nreq[m_owner] = 1'b0;
         apply(1'b0, nreq);
      end

      // Single source 2 with random data toggling.
      cycle(1'b1, 4'b0000);
      repeat (6) cycle(1'b0, 4'b0100);

      // Sole re-requester wins again straight out of GAP.
      repeat (3) cycle(1'b0, 4'b0010);
      cycle(1'b0, 4'b0000);
      repeat (3) cycle(1'b0, 4'b0010);

      // Reset while source 3 holds the grant.
      repeat (4) cycle(1'b0, 4'b1000);
      cycle(1'b1, 4'b1000);
      repeat (2) cycle(1'b0, 4'b0000);

      // Long hold by source 0 with source 1 waiting.
      cycle(1'b1, 4'b0000);
      repeat (14) cycle(1'b0, 4'b0011);

      // Random sticky requests with occasional reset.
      nreq = 4'b0000;
      repeat (400) begin
         nreq = nreq ^ (4'($urandom) & 4'($urandom));
         cycle(($urandom_range(0, 63) == 0), nreq);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drain", 9'(sb_q.size()), 9'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
